// File: rtl/stepper_line_tracker.sv
// rtl/stepper_line_tracker.sv - filtered half-step decoder and dot-line position tracker
module stepper_line_tracker #(
  parameter int STEPS_PER_LINE = 8,
  parameter int FILTER_CYCLES  = 4,
  parameter int LINE_WIDTH     = 16,
  parameter int IDLE_TIMEOUT   = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  motor_phase_a,
  input  logic                  motor_phase_b,
  input  logic                  motor_phase_na,
  input  logic                  motor_phase_nb,
  input  logic                  clear,
  output logic                  line_advance_tick,
  output logic                  line_reverse_tick,
  output logic [LINE_WIDTH-1:0] line_position,
  output logic                  direction,
  output logic                  moving,
  output logic                  invalid_step,
  output logic                  invalid_state
);

  // Filter counter saturates at FILTER_CYCLES-1; the pattern is passed on the
  // edge at which it has been seen for the FILTER_CYCLES-th consecutive time.
  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] SAT_CNT = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0] HIT_CNT = (FILTER_CYCLES >= 2) ? CW'(FILTER_CYCLES - 2) : '0;

  localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  // Accumulator holds +/-(STEPS_PER_LINE-1) plus a +/-2 step before wrapping.
  localparam int AW = $clog2(STEPS_PER_LINE) + 3;
  localparam logic signed [AW-1:0] SPL     = AW'(STEPS_PER_LINE);
  localparam logic signed [AW-1:0] NEG_SPL = -AW'(STEPS_PER_LINE);

  logic [3:0]  phase_raw;
  logic [3:0]  sync1, sync2, cand;
  logic [CW-1:0] stable_cnt;
  logic        filter_hit;
  logic        pass_valid;
  logic [3:0]  pass_pat;
  logic        acc_valid;
  logic [3:0]  acc_pat;

  logic        ref_idle;
  logic [2:0]  ref_idx;
  logic signed [AW-1:0] acc;
  logic [IW-1:0] idle_cnt;

  logic        pat_illegal, pat_idle;
  logic [2:0]  pat_idx;
  logic [2:0]  diff;
  logic signed [2:0] step;
  logic        step_valid, bad_step, bad_state;
  logic signed [AW-1:0] sum;

  assign phase_raw = {motor_phase_a, motor_phase_b, motor_phase_na, motor_phase_nb};

  assign filter_hit = (FILTER_CYCLES == 1) ? (sync2 != cand)
                                           : ((sync2 == cand) && (stable_cnt == HIT_CNT));

  // Synchronise the raw phases and qualify them with a stability counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      cand       <= '0;
      stable_cnt <= '0;
      pass_valid <= 1'b0;
      pass_pat   <= '0;
      acc_valid  <= 1'b0;
      acc_pat    <= '0;
    end else begin
      sync1      <= phase_raw;
      sync2      <= sync1;
      pass_valid <= filter_hit;
      if (filter_hit) pass_pat <= sync2;
      acc_valid  <= pass_valid;
      if (pass_valid) acc_pat <= pass_pat;
      if (sync2 != cand) begin
        cand       <= sync2;
        stable_cnt <= '0;
      end else if (stable_cnt != SAT_CNT) begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  // Decode the accepted pattern and classify the transition from the reference.
  always_comb begin
    pat_illegal = (acc_pat[3] & acc_pat[1]) | (acc_pat[2] & acc_pat[0]);
    pat_idle    = (acc_pat == 4'b0000);
    case (acc_pat)
      4'b1000: pat_idx = 3'd0;
      4'b1100: pat_idx = 3'd1;
      4'b0100: pat_idx = 3'd2;
      4'b0110: pat_idx = 3'd3;
      4'b0010: pat_idx = 3'd4;
      4'b0011: pat_idx = 3'd5;
      4'b0001: pat_idx = 3'd6;
      4'b1001: pat_idx = 3'd7;
      default: pat_idx = 3'd0;
    endcase
    diff       = pat_idx - ref_idx;
    step       = 3'sd0;
    step_valid = 1'b0;
    bad_step   = 1'b0;
    bad_state  = 1'b0;
    if (acc_valid) begin
      if (pat_illegal) begin
        bad_state = 1'b1;
      end else if (!pat_idle && !ref_idle) begin
        case (diff)
          3'd1: begin step = 3'sd1;  step_valid = 1'b1; end
          3'd2: begin step = 3'sd2;  step_valid = 1'b1; end
          3'd7: begin step = -3'sd1; step_valid = 1'b1; end
          3'd6: begin step = -3'sd2; step_valid = 1'b1; end
          3'd3, 3'd4, 3'd5: bad_step = 1'b1;
          default: step = 3'sd0;
        endcase
      end
    end
    sum = acc + {{(AW-3){step[2]}}, step};
  end

  // Track the reference, accumulate half-steps into lines and drive the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_idle          <= 1'b1;
      ref_idx           <= '0;
      acc               <= '0;
      idle_cnt          <= '0;
      line_advance_tick <= 1'b0;
      line_reverse_tick <= 1'b0;
      line_position     <= '0;
      direction         <= 1'b0;
      moving            <= 1'b0;
      invalid_step      <= 1'b0;
      invalid_state     <= 1'b0;
    end else begin
      line_advance_tick <= 1'b0;
      line_reverse_tick <= 1'b0;
      invalid_step      <= bad_step;
      invalid_state     <= bad_state;

      if (acc_valid && !pat_illegal) begin
        if (pat_idle) begin
          ref_idle <= 1'b1;
        end else begin
          ref_idle <= 1'b0;
          ref_idx  <= pat_idx;
        end
      end

      // A clear wins over a coincident step: the step is dropped entirely.
      if (clear) begin
        acc           <= '0;
        line_position <= '0;
      end else if (step_valid) begin
        direction <= ~step[2];
        if (sum >= SPL) begin
          acc               <= sum - SPL;
          line_advance_tick <= 1'b1;
          line_position     <= line_position + 1'b1;
        end else if (sum <= NEG_SPL) begin
          acc               <= sum + SPL;
          line_reverse_tick <= 1'b1;
          line_position     <= line_position - 1'b1;
        end else begin
          acc <= sum;
        end
      end

      if (step_valid && !clear) begin
        moving   <= 1'b1;
        idle_cnt <= '0;
      end else if (moving) begin
        if (idle_cnt == IDLE_LAST) moving <= 1'b0;
        else idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stepper_line_tracker.sv
// tb/tb_stepper_line_tracker.sv - scoreboard bench for stepper_line_tracker
module tb_stepper_line_tracker;
  localparam int F  = 4;
  localparam int LW = 4;
  localparam int T  = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic [3:0] ph = 4'b0000;
  logic adv, rev, istep, istate, dir, mov;
  logic [LW-1:0] pos;

  int n_checks = 0;
  int n_pass = 0;
  logic [8:0] exp_q[$];

  stepper_line_tracker #(
    .STEPS_PER_LINE(8), .FILTER_CYCLES(F), .LINE_WIDTH(LW), .IDLE_TIMEOUT(T)
  ) dut (
    .clk(clk), .reset(reset),
    .motor_phase_a(ph[3]), .motor_phase_b(ph[2]),
    .motor_phase_na(ph[1]), .motor_phase_nb(ph[0]),
    .clear(clear),
    .line_advance_tick(adv), .line_reverse_tick(rev),
    .line_position(pos), .direction(dir), .moving(mov),
    .invalid_step(istep), .invalid_state(istate)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] pat(int i);
    case (i % 8)
      0: pat = 4'b1000;
      1: pat = 4'b1100;
      2: pat = 4'b0100;
      3: pat = 4'b0110;
      4: pat = 4'b0010;
      5: pat = 4'b0011;
      6: pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
  endtask

  task automatic push(logic a, logic r, logic s, logic st, logic d, int p);
    logic [3:0] p4;
    p4 = 4'(p);
    exp_q.push_back({a, r, s, st, d, p4});
  endtask

  task automatic hold(logic [3:0] p, int n);
    ph = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every tick or error pulse must match the next expected event.
  always @(negedge clk) begin
    logic [8:0] got, want;
    if (!reset && (adv || rev || istep || istate)) begin
      got = {adv, rev, istep, istate, dir, pos};
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL event: unexpected %b at %0t", got, $time);
      end else begin
        want = exp_q.pop_front();
        check("event", 16'(got), 16'(want));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ticks", {adv, rev, istep, istate}, 0);
    check("reset_pos", pos, 0);
    check("reset_dir_mov", {dir, mov}, 0);
    reset = 1'b0;
    hold(4'b0000, 5);

    // forward half-steps: one advance on the 8th counted step
    hold(pat(0), 10);
    for (int i = 1; i < 8; i++) hold(pat(i), 10);
    push(1, 0, 0, 0, 1, 1);
    ph = pat(0);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (adv && lat < 0) lat = k;
    end
    check("advance_latency", 16'(lat), 16'(F + 4));
    hold(pat(1), 10);
    check("fwd_pos", pos, 1);
    check("fwd_dir", dir, 1);
    hold(4'b0000, 10);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear_pos", pos, 0);

    // full steps forward then back
    hold(pat(0), 10);
    hold(pat(2), 10); hold(pat(4), 10); hold(pat(6), 10);
    push(1, 0, 0, 0, 1, 1);
    hold(pat(0), 10);
    hold(pat(6), 10); hold(pat(4), 10);
    check("no_reverse_yet", pos, 1);
    push(0, 1, 0, 0, 0, 0);
    hold(pat(2), 10); hold(pat(0), 10);
    check("rev_pos", pos, 0);
    check("rev_dir", dir, 0);

    // glitch rejection with accumulator one short of a line
    for (int i = 1; i < 8; i++) hold(pat(i), 10);
    hold(pat(0), 3);
    hold(pat(7), 10);
    check("glitch_pos", pos, 0);
    push(1, 0, 0, 0, 1, 1);
    hold(pat(0), 4);
    hold(pat(1), 10);
    check("four_cycle_pos", pos, 1);

    // illegal pattern and illegal transition
    push(0, 0, 0, 1, 1, 1);
    hold(4'b1010, 10);
    hold(pat(0), 10);
    push(0, 0, 1, 0, 0, 1);
    hold(pat(4), 10);
    hold(pat(5), 10);
    check("after_bad_step_dir", dir, 1);
    check("after_bad_step_mov", mov, 1);

    // wrap of a 4-bit position
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    for (int s = 1; s <= 32; s++) begin
      if (s % 4 == 0) push(1, 0, 0, 0, 1, s / 4);
      hold(pat(5 + 2 * s), 10);
    end
    check("wrap_pos", pos, 4'b1000);

    // clear coincident with a line-completing step
    hold(pat(7), 10); hold(pat(1), 10); hold(pat(3), 10);
    ph = pat(5);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 7) clear = 1'b1;
      if (k == 8) clear = 1'b0;
    end
    check("clear_step_pos", pos, 0);

    // moving timeout
    ph = pat(7);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 8)  check("moving_set", mov, 1);
      if (k == 27) check("moving_hold", mov, 1);
      if (k == 28) check("moving_drop", mov, 0);
    end

    // reset mid-sequence
    push(1, 0, 0, 0, 1, 1);
    hold(pat(1), 10); hold(pat(3), 10); hold(pat(5), 10);
    check("pre_reset_pos", pos, 1);
    ph = pat(7);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_outs", {adv, rev, istep, istate, dir, mov}, 0);
    check("async_reset_pos", pos, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    hold(pat(7), 10);
    check("post_reset_no_step", {dir, mov}, 0);
    hold(pat(1), 10);
    check("post_reset_step", {dir, mov}, 2'b11);

    hold(4'b0000, 10);
    check("queue_empty", 16'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/stepper_line_tracker.md
# stepper_line_tracker

Parametrised paper-feed tracker for the print mechanism. It filters the four stepper phase inputs and decodes them as an 8-state half-step sequence. It accumulates signed half-steps into dot lines and reports line advance/reverse ticks, an absolute line position, direction, motion activity and protocol errors. It replaces the fixed 4-full-step-per-line tracker and feeds the line-counting logic of the analyser.

## Interface
- `STEPS_PER_LINE`, 8: half-steps per dot line; must be ≥ 2.
- `FILTER_CYCLES`, 4: consecutive stable cycles before a phase pattern is accepted; must be ≥ 1.
- `LINE_WIDTH`, 16: width of signed `line_position`.
- `IDLE_TIMEOUT`, 1000: cycles without an accepted step before `moving` drops; must be ≥ 1.
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `motor_phase_a`, `motor_phase_b`, `motor_phase_na`, `motor_phase_nb` in 1 each: raw phase drive levels, asynchronous to `clk`.
- `clear` in 1: synchronous clear of the accumulator and `line_position`.
- `line_advance_tick` out 1: one-cycle pulse per line advanced.
- `line_reverse_tick` out 1: one-cycle pulse per line reversed.
- `line_position` out LINE_WIDTH: signed net line count, wraps modulo 2^LINE_WIDTH.
- `direction` out 1: 1 = last counted step advanced, 0 = reversed.
- `moving` out 1: a step was counted within the last IDLE_TIMEOUT cycles.
- `invalid_step` out 1: one-cycle pulse on an illegal transition.
- `invalid_state` out 1: one-cycle pulse on acceptance of an illegal phase pattern.

## Operation
- Input path: 2-FF synchroniser on the vector {a,b,na,nb}. A candidate register and stability counter follow. The synchronised value replaces the accepted pattern once it has equalled the candidate for FILTER_CYCLES consecutive cycles. Any change reloads the candidate and zeroes the counter.
- Decode of accepted {a,b,na,nb} to index: 1000=0, 1100=1, 0100=2, 0110=3, 0010=4, 0011=5, 0001=6, 1001=7.
- 0000 = IDLE, meaning de-energised. It is legal, never counted, and the reference becomes IDLE.
- Any pattern with a&na or b&nb is illegal. It pulses `invalid_state`, and the reference index is unchanged.
- On each acceptance of a legal index with a non-IDLE reference, compute delta = (new − ref) mod 8:
  - 1 → +1; 2 → +2; 7 → −1; 6 → −2; 0 → nothing.
  - 3, 4 or 5 → pulse `invalid_step` with no count change. The reference still updates to the new index.
- Acceptance from IDLE to a legal index: no count, no error; the reference is set.
- Accumulator: signed, range −(STEPS_PER_LINE−1)..+(STEPS_PER_LINE−1), with acc += delta.
  - If acc ≥ STEPS_PER_LINE: subtract STEPS_PER_LINE, pulse advance, `line_position`+1.
  - If acc ≤ −STEPS_PER_LINE: add STEPS_PER_LINE, pulse reverse, `line_position`−1.
  - Mixed directions cancel naturally.
- `direction` updates on every counted (non-zero) delta. `moving` is set on a counted delta and cleared by an idle counter reaching IDLE_TIMEOUT; the counter reloads on each counted delta.
- `clear`: zeroes the accumulator and `line_position`, suppresses ticks that cycle, and keeps the reference, `direction` and `moving`. A clear coincident with a step discards that step.
- `line_position` wraps: +max+1 → −2^(LINE_WIDTH−1), and the reverse.

## Timing
- Reset values: all outputs 0; accumulator 0; reference IDLE; synchroniser, candidate and filter counter 0.
- Latency:
  - A phase change present before clock edge N, and held stable, is accepted at edge N+2+FILTER_CYCLES.
  - The tick, `invalid_*`, `line_position` and `direction` update at edge N+3+FILTER_CYCLES.
  - All outputs are registered.
- Throughput: at most one acceptance per FILTER_CYCLES+1 cycles. Patterns shorter than FILTER_CYCLES cycles are ignored entirely (glitch rejection).
- Ticks and error flags are high for exactly one cycle per event. Advance and reverse are never both high.
- `reset` assertion mid-operation forces reset values immediately. After release, the first legal pattern only sets the reference.

## Test plan
- Defaults, forward half-step sequence 0→1→…→7→0→1, each held 10 cycles → `line_advance_tick` pulses once, on the 8th counted step; `line_position`=1; `direction`=1; tick is FILTER_CYCLES+3 edges after the input change.
- Full steps 0→2→4→6→0 then 0→6→4 → one advance, then accumulator −4 with no reverse tick. Continue 4→2→0 → one reverse tick; `line_position`=0.
- Glitch: phase 1100 for 3 cycles between stable 1000 states → no acceptance, no tick, no error. 1100 held for 4 cycles → one +1 step.
- Illegal: 1010 held → `invalid_state` pulse, no count. Transition 0→4 → `invalid_step` pulse, reference=4, next 4→5 counts +1.
- LINE_WIDTH=4: 8 advanced lines from 0 → `line_position` wraps 7→−8. Assert `clear` coincident with an accepted step → `line_position`=0, no tick.
- IDLE_TIMEOUT=20: `moving` drops 20 cycles after the last counted step. Reset mid-sequence → all outputs 0, and the next legal pattern produces no step.
